pipelined_add_sub: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor. Operands of WIDTH bits are split into STAGES equal slices; each pipeline stage adds one slice and registers its carry forward to the next stage. A valid/ready handshake on the input and output sides lets the block sit between datapath producers and consumers, such as an ALU issue stage and a writeback buffer. Throughput is one operation per cycle when not stalled. It is the multi-cycle, high-frequency successor to the single-cycle ripple adder.

---
 rtl/arith_pkg.sv | 14 +
 rtl/add_slice.sv | 23 ++
 rtl/pipelined_add_sub.sv | 143 ++++++++++++++
 tb/tb_pipelined_add_sub.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: default datapath width, operation encoding
// and the slice-width helper used by the pipelined adder/subtractor.
package arith_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int slice_width(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/add_slice.sv
// Combinational SW-bit adder slice. Besides the carry out it exposes the carry
// into its top bit so the last slice can derive signed overflow.
module add_slice #(
    parameter int SW = 8
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic [SW-1:0] s,
    output logic          cout,
    output logic          c_msb_in
);

    logic [SW:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, cin};
    assign s     = total[SW-1:0];
    assign cout  = total[SW];

    // The sum bit is a^b^carry_in, so the carry into the MSB falls out by XOR.
    assign c_msb_in = a[SW-1] ^ b[SW-1] ^ total[SW-1];

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement adder/subtractor: one slice per stage, carries
// registered between stages, global-stall valid/ready handshake.
module pipelined_add_sub
    import arith_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int SW = slice_width(WIDTH, STAGES);

    if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
        $fatal(1, "pipelined_add_sub: WIDTH must be >= 2 and divisible by STAGES");
    end

    logic adv;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO  = k * SW;
        localparam int REM = WIDTH - LO;

        logic [REM-1:0]   a_i;
        logic [REM-1:0]   b_i;
        logic             sub_i;
        logic             c_i;
        logic             v_i;
        logic [SW-1:0]    b_slice;
        logic [SW-1:0]    s;
        logic             co;
        logic             c_msb;
        logic [LO+SW-1:0] r_n;
        logic             v_q;
        logic [LO+SW-1:0] r_q;

        // Stage k consumes the lowest remaining operand slice; the operands
        // still to be added travel upward, already-computed bits travel below.
        if (k == 0) begin : g_first
            assign a_i   = a;
            assign b_i   = b;
            assign sub_i = sub;
            assign c_i   = (sub == OP_SUB) ? 1'b1 : cin;
            assign v_i   = in_valid;
            assign r_n   = s;
        end else begin : g_next
            assign a_i   = g_stage[k-1].g_carry.a_q;
            assign b_i   = g_stage[k-1].g_carry.b_q;
            assign sub_i = g_stage[k-1].g_carry.sub_q;
            assign c_i   = g_stage[k-1].g_carry.c_q;
            assign v_i   = g_stage[k-1].v_q;
            assign r_n   = {s, g_stage[k-1].r_q};
        end

        assign b_slice = b_i[SW-1:0] ^ {SW{sub_i == OP_SUB}};

        add_slice #(
            .SW(SW)
        ) u_slice (
            .a       (a_i[SW-1:0]),
            .b       (b_slice),
            .cin     (c_i),
            .s       (s),
            .cout    (co),
            .c_msb_in(c_msb)
        );

        // Valid bit and accumulated result advance together under the global enable.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q <= 1'b0;
                r_q <= '0;
            end else if (adv) begin
                v_q <= v_i;
                r_q <= r_n;
            end
        end

        if (k < STAGES - 1) begin : g_carry
            logic [REM-SW-1:0] a_q;
            logic [REM-SW-1:0] b_q;
            logic              sub_q;
            logic              c_q;
            logic              unused_c_msb;

            assign unused_c_msb = c_msb;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    sub_q <= 1'b0;
                    c_q   <= 1'b0;
                end else if (adv) begin
                    a_q   <= a_i[REM-1:SW];
                    b_q   <= b_i[REM-1:SW];
                    sub_q <= sub_i;
                    c_q   <= co;
                end
            end
        end else begin : g_flags
            logic cout_q;
            logic ovf_q;
            logic zero_q;

            // Flags come from the top slice and the fully assembled sum.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cout_q <= 1'b0;
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (adv) begin
                    cout_q <= co;
                    ovf_q  <= c_msb ^ co;
                    zero_q <= (r_n == '0);
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].v_q;
    assign sum       = g_stage[STAGES-1].r_q;
    assign cout      = g_stage[STAGES-1].g_flags.cout_q;
    assign overflow  = g_stage[STAGES-1].g_flags.ovf_q;
    assign zero      = g_stage[STAGES-1].g_flags.zero_q;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed bench for pipelined_add_sub: default 32/4 instance plus 8/1, 16/2
// and 64/8 instances fed the same streaming vectors.
module tb_pipelined_add_sub;

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic        sw_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        sub;

    logic        m_ready, m_valid, m_cout, m_ovf, m_zero;
    logic [31:0] m_sum;
    logic        s8_ready, s8_valid, s8_cout, s8_ovf, s8_zero;
    logic [7:0]  s8_sum;
    logic        s16_ready, s16_valid, s16_cout, s16_ovf, s16_zero;
    logic [15:0] s16_sum;
    logic        s64_ready, s64_valid, s64_cout, s64_ovf, s64_zero;
    logic [63:0] s64_sum;

    int assertCount = 0;
    int failCount   = 0;

    logic [63:0] va  [16];
    logic [63:0] vb  [16];
    logic        vc  [16];
    logic        vsb [16];

    always #5 clk = ~clk;

    pipelined_add_sub #(.WIDTH(32), .STAGES(4)) u_main (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_ready),
        .a(a[31:0]), .b(b[31:0]), .cin(cin), .sub(sub),
        .out_valid(m_valid), .out_ready(out_ready), .sum(m_sum),
        .cout(m_cout), .overflow(m_ovf), .zero(m_zero)
    );

    pipelined_add_sub #(.WIDTH(8), .STAGES(1)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s8_ready),
        .a(a[7:0]), .b(b[7:0]), .cin(cin), .sub(sub),
        .out_valid(s8_valid), .out_ready(sw_ready), .sum(s8_sum),
        .cout(s8_cout), .overflow(s8_ovf), .zero(s8_zero)
    );

    pipelined_add_sub #(.WIDTH(16), .STAGES(2)) u_w16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s16_ready),
        .a(a[15:0]), .b(b[15:0]), .cin(cin), .sub(sub),
        .out_valid(s16_valid), .out_ready(sw_ready), .sum(s16_sum),
        .cout(s16_cout), .overflow(s16_ovf), .zero(s16_zero)
    );

    pipelined_add_sub #(.WIDTH(64), .STAGES(8)) u_w64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s64_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(s64_valid), .out_ready(sw_ready), .sum(s64_sum),
        .cout(s64_cout), .overflow(s64_ovf), .zero(s64_zero)
    );

    // Reference: plain wide arithmetic, overflow from operand/result signs.
    function automatic res_t refModel(input logic [63:0] x, input logic [63:0] y,
                                      input logic ci, input logic sb, input int w);
        logic [63:0] mask;
        logic [63:0] xx;
        logic [63:0] yy;
        logic [64:0] full;
        res_t        r;
        mask   = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        xx     = x & mask;
        yy     = (sb ? ~y : y) & mask;
        full   = {1'b0, xx} + {1'b0, yy} + {64'd0, (sb ? 1'b1 : ci)};
        r.sum  = full[63:0] & mask;
        r.cout = full[w];
        r.ovf  = (xx[w-1] == yy[w-1]) && (r.sum[w-1] != xx[w-1]);
        r.zero = (r.sum == 64'd0);
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [63:0] x, input logic [63:0] y,
                                 input logic ci, input logic sb);
        in_valid = v;
        a        = x;
        b        = y;
        cin      = ci;
        sub      = sb;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic runSingle(input string tag, input logic [31:0] x, input logic [31:0] y,
                             input logic ci, input logic sb, input logic [31:0] es,
                             input logic ec, input logic eo, input logic ez);
        applyStimulus(1'b1, {32'd0, x}, {32'd0, y}, ci, sb);
        nextCycle();
        in_valid = 1'b0;
        nextCycle();
        nextCycle();
        checkOutput({tag, "_early"}, 64'(m_valid), 64'd0);
        nextCycle();
        checkOutput({tag, "_valid"}, 64'(m_valid), 64'd1);
        checkOutput({tag, "_sum"},   64'(m_sum),   64'(es));
        checkOutput({tag, "_cout"},  64'(m_cout),  64'(ec));
        checkOutput({tag, "_ovf"},   64'(m_ovf),   64'(eo));
        checkOutput({tag, "_zero"},  64'(m_zero),  64'(ez));
        nextCycle();
    endtask

    task automatic checkDut(input string name, input int w, input int lat, input int cyc,
                            input logic v, input logic rdy, input logic [63:0] s,
                            input logic co, input logic ov, input logic z);
        int   idx;
        res_t r;
        idx = cyc - lat;
        checkOutput($sformatf("%s_ready_c%0d", name, cyc), 64'(rdy), 64'd1);
        if (idx >= 0 && idx < 16) begin
            r = refModel(va[idx], vb[idx], vc[idx], vsb[idx], w);
            checkOutput($sformatf("%s_valid_%0d", name, idx), 64'(v), 64'd1);
            checkOutput($sformatf("%s_sum_%0d", name, idx), s, r.sum);
            checkOutput($sformatf("%s_cout_%0d", name, idx), 64'(co), 64'(r.cout));
            checkOutput($sformatf("%s_ovf_%0d", name, idx), 64'(ov), 64'(r.ovf));
            checkOutput($sformatf("%s_zero_%0d", name, idx), 64'(z), 64'(r.zero));
        end else begin
            checkOutput($sformatf("%s_idle_c%0d", name, cyc), 64'(v), 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [63:0] bpA [6];
        logic [63:0] bpB [6];
        logic        bpS [6];
        res_t        r;
        int          sent;
        int          recv;

        rst       = 1'b1;
        out_ready = 1'b1;
        sw_ready  = 1'b1;
        applyStimulus(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_valid", 64'(m_valid), 64'd0);
        checkOutput("rst_sum",   64'(m_sum),   64'd0);
        checkOutput("rst_cout",  64'(m_cout),  64'd0);
        checkOutput("rst_ovf",   64'(m_ovf),   64'd0);
        checkOutput("rst_zero",  64'(m_zero),  64'd0);
        checkOutput("rst_w64_valid", 64'(s64_valid), 64'd0);
        rst = 1'b0;
        #1;
        checkOutput("rst_ready", 64'(m_ready), 64'd1);
        @(negedge clk);

        // Directed single operations
        runSingle("ripple",   32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        runSingle("ovf_add",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        runSingle("ovf_sub",  32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        runSingle("borrow",   32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        runSingle("zero_sub", 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        repeat (10) nextCycle();

        // Streaming across all parameterisations
        for (int i = 0; i < 16; i++) begin
            va[i]  = {$urandom(), $urandom()};
            vb[i]  = {$urandom(), $urandom()};
            vc[i]  = 1'($urandom_range(0, 1));
            vsb[i] = 1'($urandom_range(0, 1));
        end
        for (int cyc = 0; cyc < 25; cyc++) begin
            checkDut("w32", 32, 4, cyc, m_valid, m_ready, 64'(m_sum), m_cout, m_ovf, m_zero);
            checkDut("w8", 8, 1, cyc, s8_valid, s8_ready, 64'(s8_sum), s8_cout, s8_ovf, s8_zero);
            checkDut("w16", 16, 2, cyc, s16_valid, s16_ready, 64'(s16_sum), s16_cout, s16_ovf, s16_zero);
            checkDut("w64", 64, 8, cyc, s64_valid, s64_ready, s64_sum, s64_cout, s64_ovf, s64_zero);
            if (cyc < 16) applyStimulus(1'b1, va[cyc], vb[cyc], vc[cyc], vsb[cyc]);
            else          in_valid = 1'b0;
            nextCycle();
        end

        // Backpressure: consumer stalls for three cycles while a result is held
        bpA[0] = 64'd1;    bpB[0] = 64'd2;    bpS[0] = 1'b0;
        bpA[1] = 64'd10;   bpB[1] = 64'd3;    bpS[1] = 1'b1;
        bpA[2] = 64'd100;  bpB[2] = 64'd200;  bpS[2] = 1'b0;
        bpA[3] = 64'd7;    bpB[3] = 64'd7;    bpS[3] = 1'b1;
        bpA[4] = 64'h1234; bpB[4] = 64'h4321; bpS[4] = 1'b0;
        bpA[5] = 64'd3;    bpB[5] = 64'd9;    bpS[5] = 1'b1;
        sent = 0;
        recv = 0;
        for (int c = 0; c < 40 && recv < 6; c++) begin
            out_ready = !(c >= 5 && c <= 7);
            if (sent < 6) applyStimulus(1'b1, bpA[sent], bpB[sent], 1'b0, bpS[sent]);
            else          in_valid = 1'b0;
            #1;
            if (m_valid) begin
                if (recv < 6) begin
                    r = refModel(bpA[recv], bpB[recv], 1'b0, bpS[recv], 32);
                    checkOutput($sformatf("bp_sum_%0d", recv), 64'(m_sum), r.sum);
                    checkOutput($sformatf("bp_zero_%0d", recv), 64'(m_zero), 64'(r.zero));
                    checkOutput($sformatf("bp_cout_%0d", recv), 64'(m_cout), 64'(r.cout));
                    if (out_ready) recv++;
                end else begin
                    checkOutput("bp_extra_result", 64'(m_valid), 64'd0);
                end
            end
            if (!out_ready && m_valid) checkOutput($sformatf("bp_stall_ready_c%0d", c), 64'(m_ready), 64'd0);
            if (in_valid && m_ready) sent++;
            nextCycle();
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        checkOutput("bp_received", 64'(recv), 64'd6);
        checkOutput("bp_drained", 64'(m_valid), 64'd0);
        repeat (10) nextCycle();

        // Reset with three operations in flight
        applyStimulus(1'b1, 64'h100, 64'h23, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 64'h200, 64'h45, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 64'h300, 64'h67, 1'b0, 1'b0);
        nextCycle();
        in_valid = 1'b0;
        nextCycle();
        checkOutput("flight_valid_before", 64'(m_valid), 64'd1);
        checkOutput("flight_sum_before", 64'(m_sum), 64'h123);
        rst = 1'b1;
        #1;
        checkOutput("flight_async_valid", 64'(m_valid), 64'd0);
        checkOutput("flight_async_sum", 64'(m_sum), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            checkOutput($sformatf("flight_discard_c%0d", c), 64'(m_valid), 64'd0);
            nextCycle();
        end
        runSingle("post_reset", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
